lif_spike_encoder: RTL and testbench
====================================

# lif_spike_encoder

Rate-coded spike transmitter that generates the `signal_in` pulse train for the LIF neuron, replacing a push-button or external stimulus with programmable, repeatable input. Software or a host FSM loads an intensity (rate) and a burst length through a valid/ready handshake. The block then emits single-cycle spikes at a density proportional to the rate, with a minimum refractory gap between spikes. It sits directly upstream of the neuron; `spike_out` wires to the neuron's `signal_in`.

## Interface

Parameters:

- `WIDTH`, 8: rate and phase-accumulator width.
- `LEN_W`, 8: burst-length and spike-counter width.
- `REFRACT`, 1: minimum number of low cycles forced after each spike. 0 means no gap.

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: block can accept a configuration. Equals (state == IDLE).
- `cfg_rate` in WIDTH: spike intensity. 0 means no spikes.
- `cfg_len` in LEN_W: spikes per burst. 0 means continuous until `stop`.
- `stop` in 1: abort the running burst.
- `spike_out` out 1: registered, one-cycle spike to the neuron.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at burst end.
- `spike_cnt` out LEN_W: spikes emitted in the current or last burst.

## Operation

- **States**: IDLE and RUN.
- **IDLE**:
  - `cfg_ready` is 1.
  - On an edge with `cfg_valid && cfg_ready`:
    - latch `rate` and `len`;
    - clear `acc`, `gap_cnt` and `spike_cnt`;
    - go to RUN.
  - `stop` is ignored.
- **RUN**, evaluated at each edge:
  - `{carry, acc} <= acc + rate`, computed at WIDTH+1 bits. The carry is the spike candidate.
  - If `gap_cnt != 0`:
    - decrement `gap_cnt`;
    - drop any candidate. The accumulator still updates.
  - Else if there is a candidate:
    - `spike_out <= 1`;
    - `spike_cnt++`;
    - `gap_cnt <= REFRACT`.
  - Otherwise `spike_out <= 0`.
  - Burst end: a spike that makes `spike_cnt == len` (with `len != 0`) also:
    - moves the block to IDLE;
    - sets `done <= 1` in the same cycle that `spike_out` is high.
  - `stop == 1` has priority over everything in RUN:
    - next state IDLE;
    - `spike_out <= 0`;
    - `done <= 1`;
    - no count change.
- **Holding values**: `spike_cnt` holds after the burst ends until the next accepted configuration. `cfg_ready` rises in the same cycle that `done` is high.
- **Zero rate**: `rate == 0` with `len != 0` never completes and must be ended with `stop`.
- **Counter overflow**: `spike_cnt` wraps modulo 2^LEN_W in continuous mode.
- **Reset values**:
  - state IDLE;
  - `cfg_ready` 1;
  - `spike_out`, `busy`, `done` all 0;
  - `spike_cnt`, `acc`, `gap_cnt` all 0.
- **Reset mid-burst**: returns to IDLE immediately; no `done` pulse.

## Timing

- **Handshake edge E0**: state becomes RUN and `busy` = 1 after E0.
- **First spike**:
  - The first accumulation happens at E1.
  - With rate 128, the first spike is visible after E2, then after E4, E6, …
- **Spike latency**: a spike is visible one cycle after the edge that produced its carry. `spike_out` is never high for 2 consecutive cycles when `REFRACT >= 1`.
- **Stop latency**: `stop` sampled at edge En gives `spike_out` = 0, `done` = 1 and `busy` = 0 after En.
- **Back-to-back bursts**: a new configuration can be accepted on the edge immediately after `done`.
- **Rate versus refractory gap**: with `REFRACT = R`, the maximum spike rate is 1/(R+1) per cycle, regardless of `rate`.

## Configuration

- Macro: `LIF_SPIKE_ENC_LFSR_EN`.
- **Defined** (stochastic Poisson-like coding):
  - The candidate is `lfsr < rate`, a strict compare, in place of the accumulator carry.
  - The LFSR is 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1.
  - Reset seed is 8'h01. It advances on every RUN cycle and is not reset by configuration.
  - `WIDTH` must be 8.
  - The refractory gap, burst length and stop rules are unchanged.
- **Undefined**: deterministic phase-accumulator coding as described above; no LFSR logic is synthesized.

## Test plan

- **Reset**: hold `rst` 2 cycles with `cfg_valid` = 1 → `cfg_ready` = 1, `spike_out` = 0, `busy` = 0, `done` = 0, `spike_cnt` = 0; no configuration is accepted.
- **Rate 128, len 3, REFRACT 1**:
  - spikes after E2, E4, E6;
  - `done` and the last spike coincide after E6;
  - `spike_cnt` = 3;
  - `cfg_ready` = 1 after E6.
- **Rate 255, len 4, REFRACT 1**:
  - spikes every other cycle (carry is dropped during the gap);
  - 4 spikes total;
  - `spike_out` is never high for 2 consecutive cycles.
- **Rate 64, len 0, stop**:
  - one spike every 4 cycles;
  - assert `stop` on the edge where a carry occurs → no spike, `done` pulse, IDLE.
- **Mid-burst reset**: assert `rst` after 2 of 5 spikes → outputs return to reset values and no `done` pulse; a new configuration (rate 128, len 1) completes normally.
- **LFSR build**: with `LIF_SPIKE_ENC_LFSR_EN`:
  - rate 0 → no spikes in 300 cycles;
  - rate 255, REFRACT 0 → exactly 254 spikes in 255 RUN cycles.

Source files
------------

// File: rtl/lif_spike_encoder.sv
// Rate-coded spike transmitter driving the LIF neuron's signal_in.
// Optional stochastic coding: define LIF_SPIKE_ENC_LFSR_EN (WIDTH must then be 8).
module lif_spike_encoder #(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int REFRACT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_rate,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             stop,
    output logic             spike_out,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] spike_cnt
);

    localparam int GAP_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] rate_q, rate_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic             spike_q, spike_d;
    logic             done_q, done_d;
    logic             cand;

`ifdef LIF_SPIKE_ENC_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;
`else
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   sum;
`endif

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        len_d   = len_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        done_d  = 1'b0;
`ifdef LIF_SPIKE_ENC_LFSR_EN
        // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
        lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d  = lfsr_q;
        cand    = (lfsr_q < rate_q);
`else
        acc_d   = acc_q;
        sum     = {1'b0, acc_q} + {1'b0, rate_q};
        cand    = sum[WIDTH];
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_d = S_RUN;
                    rate_d  = cfg_rate;
                    len_d   = cfg_len;
                    gap_d   = '0;
                    cnt_d   = '0;
`ifndef LIF_SPIKE_ENC_LFSR_EN
                    acc_d   = '0;
`endif
                end
            end
            default: begin
`ifdef LIF_SPIKE_ENC_LFSR_EN
                lfsr_d = {lfsr_q[6:0], lfsr_fb};
`endif
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
`ifndef LIF_SPIKE_ENC_LFSR_EN
                    acc_d = sum[WIDTH-1:0];
`endif
                    // Candidates arriving during the refractory gap are discarded.
                    if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end else if (cand) begin
                        spike_d = 1'b1;
                        cnt_d   = cnt_inc;
                        gap_d   = GAP_W'(REFRACT);
                        if ((len_q != '0) && (cnt_inc == len_q)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rate_q  <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef LIF_SPIKE_ENC_LFSR_EN
            lfsr_q  <= 8'h01;
`else
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
            done_q  <= done_d;
`ifdef LIF_SPIKE_ENC_LFSR_EN
            lfsr_q  <= lfsr_d;
`else
            acc_q   <= acc_d;
`endif
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign spike_out = spike_q;
    assign done      = done_q;
    assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_spike_encoder.sv
// Self-checking bench for lif_spike_encoder: burst table, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_lif_spike_encoder;

    localparam int W  = 8;
    localparam int LW = 8;
`ifdef LIF_SPIKE_ENC_LFSR_EN
    localparam int RF = 0;
`else
    localparam int RF = 1;
`endif

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_rate;
    logic [LW-1:0] cfg_len;
    logic          stop;
    logic          spike_out;
    logic          busy;
    logic          done;
    logic [LW-1:0] spike_cnt;

    lif_spike_encoder #(
        .WIDTH  (W),
        .LEN_W  (LW),
        .REFRACT(RF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_rate (cfg_rate),
        .cfg_len  (cfg_len),
        .stop     (stop),
        .spike_out(spike_out),
        .busy     (busy),
        .done     (done),
        .spike_cnt(spike_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the k-th RUN cycle carries when floor(k*rate/2^W) steps up.
    bit     m_run   = 0;
    longint m_k     = 0;
    longint m_rate  = 0;
    int     m_len   = 0;
    int     m_gap   = 0;
    int     m_cnt   = 0;
    bit     m_spike = 0;
    bit     m_done  = 0;
    bit     prev_spike = 0;

    task automatic model_step();
        bit c;
        if (rst) begin
            m_run = 0; m_k = 0; m_rate = 0; m_len = 0;
            m_gap = 0; m_cnt = 0; m_spike = 0; m_done = 0;
        end else if (!m_run) begin
            m_spike = 0; m_done = 0;
            if (cfg_valid) begin
                m_run = 1; m_rate = longint'(cfg_rate); m_len = int'(cfg_len);
                m_k = 0; m_gap = 0; m_cnt = 0;
            end
        end else begin
            m_spike = 0; m_done = 0;
            if (stop) begin
                m_run = 0; m_done = 1;
            end else begin
                m_k++;
                c = ((m_k * m_rate) >> W) != (((m_k - 1) * m_rate) >> W);
                if (m_gap > 0) m_gap--;
                else if (c) begin
                    m_spike = 1;
                    m_cnt = (m_cnt + 1) % (1 << LW);
                    m_gap = RF;
                    if (m_len != 0 && m_cnt == m_len) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        longint act, exp;
        @(posedge clk);
        model_step();
        #1;
`ifndef LIF_SPIKE_ENC_LFSR_EN
        act = longint'({cfg_ready, busy, spike_out, done, spike_cnt});
        exp = (longint'(!m_run) << 11) | (longint'(m_run) << 10) |
              (longint'(m_spike) << 9) | (longint'(m_done) << 8) | longint'(m_cnt);
        check("model_outputs", act, exp);
        if (spike_out) check("no_back_to_back", longint'(prev_spike), 0);
`endif
        prev_spike = spike_out;
    endtask

    typedef struct {
        int rate;
        int len;
        int first_edge;
        int done_edge;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int edges, nsp, first_e, done_e;
        rst = 1'b1; cfg_valid = 1'b1; cfg_rate = 8'd128; cfg_len = 8'd3; stop = 1'b0;
        tick();
        tick();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_spike", spike_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", spike_cnt, 0);
        rst = 1'b0; cfg_valid = 1'b0;
        tick();

`ifdef LIF_SPIKE_ENC_LFSR_EN
        cfg_valid = 1'b1; cfg_rate = 8'd0; cfg_len = 8'd0;
        tick();
        cfg_valid = 1'b0;
        nsp = 0;
        for (int i = 0; i < 300; i++) begin tick(); if (spike_out) nsp++; end
        check("lfsr_rate0_spikes", nsp, 0);
        stop = 1'b1; tick(); stop = 1'b0; tick();
        cfg_valid = 1'b1; cfg_rate = 8'd255; cfg_len = 8'd0;
        tick();
        cfg_valid = 1'b0;
        nsp = 0;
        for (int i = 0; i < 255; i++) begin tick(); if (spike_out) nsp++; end
        check("lfsr_rate255_spikes", nsp, 254);
        stop = 1'b1; tick(); stop = 1'b0; tick();
        check("lfsr_stop_idle", cfg_ready, 1);
`else
        vecs[0] = '{rate: 128, len: 3, first_edge: 2,   done_edge: 6};
        vecs[1] = '{rate: 255, len: 4, first_edge: 2,   done_edge: 8};
        vecs[2] = '{rate: 64,  len: 2, first_edge: 4,   done_edge: 8};
        vecs[3] = '{rate: 1,   len: 1, first_edge: 256, done_edge: 256};
        vecs[4] = '{rate: 200, len: 3, first_edge: 2,   done_edge: 6};

        foreach (vecs[v]) begin
            cfg_valid = 1'b1; cfg_rate = W'(vecs[v].rate); cfg_len = LW'(vecs[v].len);
            tick();
            check("tbl_busy_after_E0", busy, 1);
            cfg_valid = 1'b0;
            edges = 0; nsp = 0; first_e = -1; done_e = -1;
            while (edges < 400 && done_e < 0) begin
                tick();
                edges++;
                if (spike_out) begin
                    nsp++;
                    if (first_e < 0) first_e = edges;
                end
                if (done) begin
                    done_e = edges;
                    check("tbl_spike_with_done", spike_out, 1);
                end
            end
            check("tbl_first_spike_edge", first_e, vecs[v].first_edge);
            check("tbl_done_edge", done_e, vecs[v].done_edge);
            check("tbl_spikes", nsp, vecs[v].len);
            check("tbl_spike_cnt", spike_cnt, vecs[v].len);
            check("tbl_cfg_ready", cfg_ready, 1);
            tick();
            check("tbl_cnt_holds", spike_cnt, vecs[v].len);
        end

        // Continuous rate 64, stop on the edge that carries the second spike.
        cfg_valid = 1'b1; cfg_rate = 8'd64; cfg_len = 8'd0;
        tick();
        cfg_valid = 1'b0;
        nsp = 0; first_e = -1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (spike_out) begin nsp++; first_e = e; end
        end
        check("stop_pre_spikes", nsp, 1);
        check("stop_pre_spike_edge", first_e, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_spike", spike_out, 0);
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_cnt", spike_cnt, 1);
        tick();
        check("stop_done_pulse", done, 0);

        // Reset after two of five spikes.
        cfg_valid = 1'b1; cfg_rate = 8'd128; cfg_len = 8'd5;
        tick();
        cfg_valid = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        check("mid_cnt_before_rst", spike_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_vals", {cfg_ready, busy, spike_out, done, spike_cnt}, 12'h800);
        tick();
        check("mid_rst_no_done", done, 0);
        cfg_valid = 1'b1; cfg_rate = 8'd128; cfg_len = 8'd1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        check("mid_new_done", {spike_out, done, cfg_ready}, 3'b111);

        // Back-to-back: a new configuration on the edge right after done.
        cfg_valid = 1'b1; cfg_rate = 8'd255; cfg_len = 8'd1;
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        check("b2b_first_done", done, 1);
        cfg_valid = 1'b1; cfg_rate = 8'd128; cfg_len = 8'd1;
        tick();
        cfg_valid = 1'b0;
        check("b2b_accepted", busy, 1);
        check("b2b_cnt_cleared", spike_cnt, 0);
        tick();
        tick();
        check("b2b_second_done", done, 1);

        // Randomized traffic, every cycle compared with the model inside tick().
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0:       cfg_rate = W'($urandom_range(0, 3));
                1:       cfg_rate = W'($urandom_range(240, 255));
                default: cfg_rate = W'($urandom);
            endcase
            cfg_len = LW'($urandom_range(0, 6));
            stop    = ($urandom_range(0, 99) < 2);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
